// File: rtl/fp_issue_ctrl_pkg.sv
// Shared types for the FP issue/writeback stage: fpnew-compatible op and
// format encodings, FSM states, the latched request record and op helpers.
package fp_issue_ctrl_pkg;

  localparam int unsigned FFLAGS_W = 5;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [2:0] {
    FP32, FP64, FP16, FP8, FP16ALT
  } fp_format_e;

  typedef enum logic [1:0] {
    RV32FNone, RV32FSingle, RV32FDouble, RV64FDouble
  } rvf_e;

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, WB
  } fp_issue_state_e;

  // Decoded fields held for the lifetime of the single outstanding op
  typedef struct packed {
    operation_e  op;
    logic        op_mod;
    fp_format_e  src_fmt;
    fp_format_e  dst_fmt;
    logic [2:0]  rnd_mode;
    logic [4:0]  waddr;
    logic        regwrite;
    logic        wr_int;
  } fp_issue_req_t;

  // Ops whose result lands in the integer RF
  function automatic logic fp_op_writes_int(operation_e op);
    return (op == CMP) || (op == CLASSIFY) || (op == F2I);
  endfunction

  // Ops where instr[14:12] is a rounding mode; the rest use it as a sub-op selector
  function automatic logic fp_rm_uses(operation_e op);
    case (op)
      FMADD, FNMSUB, ADD, MUL, DIV, SQRT, F2F, F2I, I2F: return 1'b1;
      default:                                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fp_fflags_acc.sv
// Sticky exception-flag accumulator; a clear and a set in the same cycle
// leaves exactly the newly set flags.
module fp_fflags_acc #(
  parameter int unsigned W = 5
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         set_i,
  input  logic [W-1:0] flags_i,
  output logic [W-1:0] flags_o
);

  logic [W-1:0] flags_q;

  // Clear first, then OR in the new flags
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) flags_q <= '0;
    else         flags_q <= (clr_i ? '0 : flags_q) | (set_i ? flags_i : '0);
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/fp_issue_ctrl.sv
// FP issue/writeback stage: captures one decoded op plus operands, hands it
// to fpnew, and writes the result to the FP or integer RF for one cycle.
module fp_issue_ctrl
  import fp_issue_ctrl_pkg::*;
#(
  parameter int unsigned FLEN = 64,
  parameter int unsigned XLEN = 32,
  parameter rvf_e        RVF  = RV64FDouble
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                dec_valid_i,
  output logic                dec_ready_o,
  input  logic                dec_illegal_i,
  input  operation_e          dec_op_i,
  input  logic                dec_op_mod_i,
  input  fp_format_e          dec_src_fmt_i,
  input  fp_format_e          dec_dst_fmt_i,
  input  logic [2:0]          dec_rm_i,
  input  logic [4:0]          dec_waddr_i,
  input  logic                dec_regwrite_i,
  input  logic [2:0]          frm_i,
  input  logic [FLEN-1:0]     rf_rdata_a_i,
  input  logic [FLEN-1:0]     rf_rdata_b_i,
  input  logic [FLEN-1:0]     rf_rdata_c_i,
  output logic [3*FLEN-1:0]   fpu_operands_o,
  output operation_e          fpu_op_o,
  output logic                fpu_op_mod_o,
  output fp_format_e          fpu_src_fmt_o,
  output fp_format_e          fpu_dst_fmt_o,
  output logic [2:0]          fpu_rnd_mode_o,
  output logic                fpu_in_valid_o,
  input  logic                fpu_in_ready_i,
  input  logic                fpu_out_valid_i,
  output logic                fpu_out_ready_o,
  input  logic [FLEN-1:0]     fpu_result_i,
  input  logic [FFLAGS_W-1:0] fpu_status_i,
  input  logic                flush_i,
  output logic                fp_we_o,
  output logic                int_we_o,
  output logic [4:0]          wb_waddr_o,
  output logic [FLEN-1:0]     fp_wdata_o,
  output logic [XLEN-1:0]     int_wdata_o,
  output logic                illegal_rm_o,
  input  logic                fflags_clr_i,
  output logic [FFLAGS_W-1:0] fflags_o,
  output logic                busy_o
);

  localparam logic EN = (RVF != RV32FNone);

  fp_issue_state_e       state_q;
  fp_issue_req_t         req_q;
  logic [2:0][FLEN-1:0]  opnd_q;
  logic                  rdy_q, in_vld_q, out_rdy_q, killed_q;
  logic                  fp_we_q, int_we_q, ill_rm_q;
  logic [FLEN-1:0]       fp_wdata_q;
  logic [XLEN-1:0]       int_wdata_q;
  logic [FFLAGS_W-1:0]   status_q;

  logic [2:0]            rm_res;
  logic                  rm_uses, rm_bad, try_acc, accept, drop_rm;
  logic [FLEN-1:0]       res_box;

  // Resolve dynamic rm and decide whether the presented op is taken
  always_comb begin
    rm_res  = (dec_rm_i == 3'b111) ? frm_i : dec_rm_i;
    rm_uses = fp_rm_uses(dec_op_i);
    rm_bad  = rm_uses && rm_res[2] && (rm_res[1:0] != 2'b00);
    try_acc = EN && (state_q == IDLE) && dec_valid_i && !flush_i && !dec_illegal_i;
    accept  = try_acc && !rm_bad;
    drop_rm = try_acc && rm_bad;
  end

  // NaN-box FP32 results into the upper FLEN-32 bits
  always_comb begin
    res_box = fpu_result_i;
    if (req_q.dst_fmt == FP32)
      for (int i = 32; i < FLEN; i++) res_box[i] = 1'b1;
  end

  // Issue FSM with registered handshake and writeback outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_q       <= '0;
      opnd_q      <= '0;
      rdy_q       <= 1'b1;
      in_vld_q    <= 1'b0;
      out_rdy_q   <= 1'b0;
      killed_q    <= 1'b0;
      fp_we_q     <= 1'b0;
      int_we_q    <= 1'b0;
      ill_rm_q    <= 1'b0;
      fp_wdata_q  <= '0;
      int_wdata_q <= '0;
      status_q    <= '0;
    end else begin
      fp_we_q  <= 1'b0;
      int_we_q <= 1'b0;
      ill_rm_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_q.op       <= dec_op_i;
            req_q.op_mod   <= dec_op_mod_i;
            req_q.src_fmt  <= dec_src_fmt_i;
            req_q.dst_fmt  <= dec_dst_fmt_i;
            req_q.rnd_mode <= rm_uses ? rm_res : dec_rm_i;
            req_q.waddr    <= dec_waddr_i;
            req_q.regwrite <= dec_regwrite_i;
            req_q.wr_int   <= fp_op_writes_int(dec_op_i);
            opnd_q         <= {rf_rdata_c_i, rf_rdata_b_i, rf_rdata_a_i};
            rdy_q          <= 1'b0;
            in_vld_q       <= 1'b1;
            out_rdy_q      <= 1'b1;
            killed_q       <= 1'b0;
            state_q        <= ISSUE;
          end
          ill_rm_q <= drop_rm;
        end
        ISSUE: begin
          if (flush_i) begin
            // fpu_in_valid_o is masked this cycle, so fpnew never saw the op
            in_vld_q  <= 1'b0;
            out_rdy_q <= 1'b0;
            rdy_q     <= 1'b1;
            state_q   <= IDLE;
          end else if (fpu_in_ready_i) begin
            in_vld_q <= 1'b0;
            if (fpu_out_valid_i) begin
              out_rdy_q   <= 1'b0;
              fp_wdata_q  <= res_box;
              int_wdata_q <= fpu_result_i[XLEN-1:0];
              status_q    <= fpu_status_i;
              fp_we_q     <= req_q.regwrite && !req_q.wr_int;
              int_we_q    <= req_q.regwrite && req_q.wr_int;
              state_q     <= WB;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (fpu_out_valid_i) begin
            out_rdy_q <= 1'b0;
            if (killed_q || flush_i) begin
              // Killed op: drain the result silently
              killed_q <= 1'b0;
              rdy_q    <= 1'b1;
              state_q  <= IDLE;
            end else begin
              fp_wdata_q  <= res_box;
              int_wdata_q <= fpu_result_i[XLEN-1:0];
              status_q    <= fpu_status_i;
              fp_we_q     <= req_q.regwrite && !req_q.wr_int;
              int_we_q    <= req_q.regwrite && req_q.wr_int;
              state_q     <= WB;
            end
          end else if (flush_i) begin
            killed_q <= 1'b1;
          end
        end
        WB: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  fp_fflags_acc #(.W(FFLAGS_W)) u_fflags (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (fflags_clr_i),
    .set_i   (state_q == WB),
    .flags_i (status_q),
    .flags_o (fflags_o)
  );

  assign dec_ready_o     = EN ? rdy_q : 1'b1;
  assign busy_o          = (state_q != IDLE);
  assign fpu_operands_o  = opnd_q;
  assign fpu_op_o        = req_q.op;
  assign fpu_op_mod_o    = req_q.op_mod;
  assign fpu_src_fmt_o   = req_q.src_fmt;
  assign fpu_dst_fmt_o   = req_q.dst_fmt;
  assign fpu_rnd_mode_o  = req_q.rnd_mode;
  assign fpu_in_valid_o  = in_vld_q && !flush_i;
  assign fpu_out_ready_o = out_rdy_q;
  assign fp_we_o         = fp_we_q;
  assign int_we_o        = int_we_q;
  assign wb_waddr_o      = req_q.waddr;
  assign fp_wdata_o      = fp_wdata_q;
  assign int_wdata_o     = int_wdata_q;
  assign illegal_rm_o    = ill_rm_q;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Directed bench for fp_issue_ctrl; the bench plays the fpnew unit by hand.
module tb_fp_issue_ctrl;
  import fp_issue_ctrl_pkg::*;

  localparam int FLEN = 64;
  localparam int XLEN = 32;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              dec_valid_i, dec_ready_o, dec_illegal_i, dec_op_mod_i, dec_regwrite_i;
  operation_e        dec_op_i;
  fp_format_e        dec_src_fmt_i, dec_dst_fmt_i;
  logic [2:0]        dec_rm_i, frm_i;
  logic [4:0]        dec_waddr_i;
  logic [FLEN-1:0]   rf_rdata_a_i, rf_rdata_b_i, rf_rdata_c_i;
  logic [3*FLEN-1:0] fpu_operands_o;
  operation_e        fpu_op_o;
  logic              fpu_op_mod_o;
  fp_format_e        fpu_src_fmt_o, fpu_dst_fmt_o;
  logic [2:0]        fpu_rnd_mode_o;
  logic              fpu_in_valid_o, fpu_in_ready_i, fpu_out_valid_i, fpu_out_ready_o;
  logic [FLEN-1:0]   fpu_result_i;
  logic [4:0]        fpu_status_i;
  logic              flush_i, fp_we_o, int_we_o, illegal_rm_o, fflags_clr_i, busy_o;
  logic [4:0]        wb_waddr_o, fflags_o;
  logic [FLEN-1:0]   fp_wdata_o;
  logic [XLEN-1:0]   int_wdata_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  fp_issue_ctrl #(.FLEN(FLEN), .XLEN(XLEN), .RVF(RV64FDouble)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o), .dec_illegal_i(dec_illegal_i),
    .dec_op_i(dec_op_i), .dec_op_mod_i(dec_op_mod_i),
    .dec_src_fmt_i(dec_src_fmt_i), .dec_dst_fmt_i(dec_dst_fmt_i),
    .dec_rm_i(dec_rm_i), .dec_waddr_i(dec_waddr_i), .dec_regwrite_i(dec_regwrite_i),
    .frm_i(frm_i),
    .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i), .rf_rdata_c_i(rf_rdata_c_i),
    .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o), .fpu_op_mod_o(fpu_op_mod_o),
    .fpu_src_fmt_o(fpu_src_fmt_o), .fpu_dst_fmt_o(fpu_dst_fmt_o), .fpu_rnd_mode_o(fpu_rnd_mode_o),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
    .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
    .flush_i(flush_i), .fp_we_o(fp_we_o), .int_we_o(int_we_o),
    .wb_waddr_o(wb_waddr_o), .fp_wdata_o(fp_wdata_o), .int_wdata_o(int_wdata_o),
    .illegal_rm_o(illegal_rm_o), .fflags_clr_i(fflags_clr_i), .fflags_o(fflags_o),
    .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample/drive 1ns after the rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_op(input operation_e op, input logic md, input fp_format_e fmt,
                          input logic [2:0] rm, input logic [4:0] wa,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    dec_valid_i    = 1'b1;
    dec_illegal_i  = 1'b0;
    dec_op_i       = op;
    dec_op_mod_i   = md;
    dec_src_fmt_i  = fmt;
    dec_dst_fmt_i  = fmt;
    dec_rm_i       = rm;
    dec_waddr_i    = wa;
    dec_regwrite_i = 1'b1;
    rf_rdata_a_i   = a;
    rf_rdata_b_i   = b;
    rf_rdata_c_i   = c;
  endtask

  initial begin
    rst_ni = 1'b0;
    dec_valid_i = 0; dec_illegal_i = 0; dec_op_i = ADD; dec_op_mod_i = 0;
    dec_src_fmt_i = FP32; dec_dst_fmt_i = FP32; dec_rm_i = 0; dec_waddr_i = 0;
    dec_regwrite_i = 0; frm_i = 0; rf_rdata_a_i = 0; rf_rdata_b_i = 0; rf_rdata_c_i = 0;
    fpu_in_ready_i = 0; fpu_out_valid_i = 0; fpu_result_i = 0; fpu_status_i = 0;
    flush_i = 0; fflags_clr_i = 0;
    repeat (2) @(posedge clk_i);
    #1;
    // Reset state
    chk("rst_dec_ready", 192'(dec_ready_o), 192'd1);
    chk("rst_busy", 192'(busy_o), 192'd0);
    chk("rst_in_valid", 192'(fpu_in_valid_o), 192'd0);
    chk("rst_out_ready", 192'(fpu_out_ready_o), 192'd0);
    chk("rst_we", 192'({fp_we_o, int_we_o, illegal_rm_o}), 192'd0);
    chk("rst_fflags", 192'(fflags_o), 192'd0);
    chk("rst_operands", 192'(fpu_operands_o), 192'd0);
    rst_ni = 1'b1;
    tick();

    // FADD.S 1.0 + 2.0, fpnew takes two cycles after the input handshake
    drive_op(ADD, 1'b0, FP32, 3'b000, 5'd5, 64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_40000000, 64'h0);
    tick();
    chk("fadd_in_valid", 192'(fpu_in_valid_o), 192'd1);
    chk("fadd_dec_ready", 192'(dec_ready_o), 192'd0);
    chk("fadd_busy", 192'(busy_o), 192'd1);
    chk("fadd_operands", 192'(fpu_operands_o),
        {64'h0, 64'hFFFFFFFF_40000000, 64'hFFFFFFFF_3F800000});
    chk("fadd_op", 192'(fpu_op_o), 192'(ADD));
    dec_valid_i = 0;
    fpu_in_ready_i = 1;
    tick();
    fpu_in_ready_i = 0;
    chk("fadd_wait_in_valid", 192'(fpu_in_valid_o), 192'd0);
    chk("fadd_wait_out_ready", 192'(fpu_out_ready_o), 192'd1);
    chk("fadd_wait_we", 192'(fp_we_o), 192'd0);
    tick();
    fpu_out_valid_i = 1; fpu_result_i = 64'h12345678_40400000; fpu_status_i = 5'b0;
    tick();
    fpu_out_valid_i = 0;
    chk("fadd_fp_we", 192'(fp_we_o), 192'd1);
    chk("fadd_int_we", 192'(int_we_o), 192'd0);
    chk("fadd_wdata", 192'(fp_wdata_o), 192'h0000_0000_FFFF_FFFF_4040_0000);
    chk("fadd_waddr", 192'(wb_waddr_o), 192'd5);
    chk("fadd_wb_dec_ready", 192'(dec_ready_o), 192'd0);
    tick();
    chk("fadd_we_once", 192'(fp_we_o), 192'd0);
    chk("fadd_post_ready", 192'(dec_ready_o), 192'd1);
    chk("fadd_post_busy", 192'(busy_o), 192'd0);
    chk("fadd_fflags", 192'(fflags_o), 192'd0);

    // FLT.S 1.0 < 2.0, same-cycle fpnew answer: minimum latency path
    drive_op(CMP, 1'b0, FP32, 3'b001, 5'd7, 64'hFFFFFFFF_3F800000, 64'hFFFFFFFF_40000000, 64'h0);
    tick();
    dec_valid_i = 0;
    chk("flt_in_valid_T1", 192'(fpu_in_valid_o), 192'd1);
    chk("flt_rm_raw", 192'(fpu_rnd_mode_o), 192'd1);
    fpu_in_ready_i = 1; fpu_out_valid_i = 1; fpu_result_i = 64'h1; fpu_status_i = 0;
    tick();
    fpu_in_ready_i = 0; fpu_out_valid_i = 0;
    chk("flt_int_we_T2", 192'(int_we_o), 192'd1);
    chk("flt_fp_we", 192'(fp_we_o), 192'd0);
    chk("flt_int_wdata", 192'(int_wdata_o), 192'd1);
    chk("flt_waddr", 192'(wb_waddr_o), 192'd7);
    tick();
    chk("flt_int_we_off", 192'(int_we_o), 192'd0);
    chk("flt_fflags", 192'(fflags_o), 192'd0);

    // FMUL with rm=DYN and frm=101: dropped with illegal_rm pulse
    frm_i = 3'b101;
    drive_op(MUL, 1'b0, FP32, 3'b111, 5'd2, 64'h1, 64'h2, 64'h0);
    tick();
    dec_valid_i = 0;
    chk("illrm_pulse", 192'(illegal_rm_o), 192'd1);
    chk("illrm_in_valid", 192'(fpu_in_valid_o), 192'd0);
    chk("illrm_dec_ready", 192'(dec_ready_o), 192'd1);
    chk("illrm_busy", 192'(busy_o), 192'd0);
    tick();
    chk("illrm_pulse_end", 192'(illegal_rm_o), 192'd0);

    // Decoder-illegal op and flush-in-IDLE both leave the stage idle
    drive_op(ADD, 1'b0, FP32, 3'b000, 5'd1, 64'h1, 64'h2, 64'h0);
    dec_illegal_i = 1;
    tick();
    dec_valid_i = 0; dec_illegal_i = 0;
    chk("dec_illegal_drop", 192'({busy_o, illegal_rm_o}), 192'd0);
    drive_op(ADD, 1'b0, FP32, 3'b000, 5'd1, 64'h1, 64'h2, 64'h0);
    flush_i = 1;
    tick();
    dec_valid_i = 0; flush_i = 0;
    chk("idle_flush_drop", 192'(busy_o), 192'd0);

    // FP64 op with rm=DYN (frm=011), fpnew not ready for 3 cycles
    frm_i = 3'b011;
    drive_op(ADD, 1'b1, FP64, 3'b111, 5'd9, 64'h3FF0000000000000, 64'h4000000000000000, 64'h1111);
    tick();
    dec_valid_i = 0;
    rf_rdata_a_i = 64'hDEAD; rf_rdata_b_i = 64'hBEEF; rf_rdata_c_i = 64'hCAFE;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_valid", 192'(fpu_in_valid_o), 192'd1);
      chk("stall_operands", 192'(fpu_operands_o),
          {64'h1111, 64'h4000000000000000, 64'h3FF0000000000000});
      chk("stall_fields", 192'({fpu_op_o, fpu_op_mod_o, fpu_rnd_mode_o}), 192'({ADD, 1'b1, 3'b011}));
      chk("stall_dec_ready", 192'(dec_ready_o), 192'd0);
      tick();
    end
    fpu_in_ready_i = 1; fpu_out_valid_i = 1;
    fpu_result_i = 64'h4008000000000000; fpu_status_i = 5'b00001;
    tick();
    fpu_in_ready_i = 0; fpu_out_valid_i = 0; fpu_status_i = 0;
    chk("stall_fp_we", 192'(fp_we_o), 192'd1);
    chk("stall_wdata_fp64", 192'(fp_wdata_o), 192'h4008000000000000);
    chk("stall_wb_dec_ready", 192'(dec_ready_o), 192'd0);
    tick();
    chk("stall_post_ready", 192'(dec_ready_o), 192'd1);
    chk("stall_fflags_nx", 192'(fflags_o), 192'b00001);

    // FDIV 1.0/0.0 raises DZ; accumulates onto NX
    drive_op(DIV, 1'b0, FP64, 3'b000, 5'd10, 64'h3FF0000000000000, 64'h0, 64'h0);
    tick();
    dec_valid_i = 0;
    fpu_in_ready_i = 1; fpu_out_valid_i = 1;
    fpu_result_i = 64'h7FF0000000000000; fpu_status_i = 5'b01000;
    tick();
    fpu_in_ready_i = 0; fpu_out_valid_i = 0; fpu_status_i = 0;
    tick();
    chk("fdiv_fflags_acc", 192'(fflags_o), 192'b01001);

    // NX op with fflags clear in its WB cycle: only NX remains
    drive_op(ADD, 1'b0, FP64, 3'b000, 5'd11, 64'h1, 64'h2, 64'h0);
    tick();
    dec_valid_i = 0;
    fpu_in_ready_i = 1; fpu_out_valid_i = 1; fpu_result_i = 64'h3; fpu_status_i = 5'b00001;
    tick();
    fpu_in_ready_i = 0; fpu_out_valid_i = 0; fpu_status_i = 0;
    chk("clr_wb_fp_we", 192'(fp_we_o), 192'd1);
    fflags_clr_i = 1;
    tick();
    fflags_clr_i = 0;
    chk("clr_then_set", 192'(fflags_o), 192'b00001);

    // Flush during WAIT: result drained, nothing written, no flags
    drive_op(MUL, 1'b0, FP64, 3'b000, 5'd3, 64'h5, 64'h6, 64'h0);
    tick();
    dec_valid_i = 0;
    fpu_in_ready_i = 1;
    tick();
    fpu_in_ready_i = 0;
    flush_i = 1;
    chk("wflush_busy", 192'(busy_o), 192'd1);
    tick();
    flush_i = 0;
    chk("wflush_still_busy", 192'({busy_o, dec_ready_o}), 192'b10);
    fpu_out_valid_i = 1; fpu_result_i = 64'hFFFF; fpu_status_i = 5'b11111;
    tick();
    fpu_out_valid_i = 0; fpu_status_i = 0;
    chk("wflush_no_we", 192'({fp_we_o, int_we_o}), 192'd0);
    chk("wflush_idle", 192'({busy_o, dec_ready_o}), 192'b01);
    tick();
    chk("wflush_fflags", 192'(fflags_o), 192'b00001);
    chk("wflush_no_we_late", 192'({fp_we_o, int_we_o}), 192'd0);

    // Next op after the flush issues normally
    drive_op(CMP, 1'b0, FP64, 3'b010, 5'd4, 64'h1, 64'h2, 64'h0);
    tick();
    dec_valid_i = 0;
    fpu_in_ready_i = 1; fpu_out_valid_i = 1; fpu_result_i = 64'h0;
    tick();
    fpu_in_ready_i = 0; fpu_out_valid_i = 0;
    chk("post_flush_int_we", 192'(int_we_o), 192'd1);
    chk("post_flush_waddr", 192'(wb_waddr_o), 192'd4);
    chk("post_flush_wdata", 192'(int_wdata_o), 192'd0);
    tick();

    // Flush during ISSUE: in_valid masked, back to IDLE with no writeback
    drive_op(ADD, 1'b0, FP32, 3'b000, 5'd6, 64'h1, 64'h2, 64'h0);
    tick();
    dec_valid_i = 0;
    flush_i = 1; fpu_in_ready_i = 1;
    #1;
    chk("iflush_in_valid_masked", 192'(fpu_in_valid_o), 192'd0);
    tick();
    flush_i = 0; fpu_in_ready_i = 0;
    chk("iflush_idle", 192'({busy_o, dec_ready_o, fp_we_o}), 192'b010);
    tick();
    chk("iflush_no_we", 192'({fp_we_o, int_we_o}), 192'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
